// File: rtl/apb4_reg_bridge_if.sv
// APB4 slave port plus register-map request bus, bundled for the bridge.
// Latency: none, signal container only.
// Backpressure: carries the pready / bus_req_stall_* / bus_ready handshakes.
interface apb4_reg_bridge_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11
);
   // APB side
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic                    pready;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pslverr;
   // register-map side
   logic                    bus_req;
   logic                    bus_req_is_wr;
   logic [ADDR_WIDTH-1:0]   bus_addr;
   logic [DATA_WIDTH-1:0]   bus_wr_data;
   logic [DATA_WIDTH-1:0]   bus_wr_biten;
   logic                    bus_req_stall_wr;
   logic                    bus_req_stall_rd;
   logic                    bus_ready;
   logic                    bus_err;
   logic [DATA_WIDTH-1:0]   bus_rd_data;

   // bridge view
   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output pready, prdata, pslverr,
      output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
      input  bus_req_stall_wr, bus_req_stall_rd, bus_ready, bus_err, bus_rd_data
   );

   // environment view: APB master and register map
   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  pready, prdata, pslverr,
      input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
      output bus_req_stall_wr, bus_req_stall_rd, bus_ready, bus_err, bus_rd_data
   );
endinterface

// File: rtl/apb4_reg_bridge.sv
// APB4 slave to single-request register bus bridge with alignment/strobe checks and WAIT timeout.
// Latency: setup edge to pready is 2 cycles minimum (IDLE -> REQ -> RESP), longer on stall/wait.
// Backpressure: stalls hold the request in REQ; bus_ready ends WAIT; pready is a single-cycle response.
module apb4_reg_bridge #(
   parameter int DATA_WIDTH       = 32,
   parameter int ADDR_WIDTH       = 11,
   parameter int TIMEOUT_CYCLES   = 16,
   parameter bit ERR_ON_UNALIGNED = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   apb4_reg_bridge_if.slave    bus,
   output logic                timeout_evt
);

   localparam int STRB_W = DATA_WIDTH / 8;
   // keep at least one counter bit so a disabled timeout still elaborates
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
   localparam logic [CNT_W-1:0]      CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);

   logic [1:0]            state;
   logic                  hold_wr;
   logic [ADDR_WIDTH-1:0] hold_addr;
   logic [DATA_WIDTH-1:0] hold_wdata;
   logic [STRB_W-1:0]     hold_strb;
   logic                  rsp_err;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic [CNT_W-1:0]      cnt;

   logic                  setup;
   logic                  unaligned;
   logic                  stall;
   logic [CNT_W-1:0]      cnt_nxt;
   logic                  timeout_hit;
   logic                  req_act;

   // decode of the current cycle's conditions
   always_comb begin
      setup       = bus.psel && !bus.penable;
      unaligned   = ERR_ON_UNALIGNED && ((bus.paddr & ALIGN_MASK) != '0);
      stall       = hold_wr ? bus.bus_req_stall_wr : bus.bus_req_stall_rd;
      cnt_nxt     = cnt + 1'b1;
      timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_nxt == CNT_LIMIT);
   end

   // transfer FSM: capture, request, wait for ack or timeout, respond
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         hold_wr     <= 1'b0;
         hold_addr   <= '0;
         hold_wdata  <= '0;
         hold_strb   <= '0;
         rsp_err     <= 1'b0;
         rsp_data    <= '0;
         cnt         <= '0;
         timeout_evt <= 1'b0;
      end else begin
         timeout_evt <= 1'b0;
         case (state)
            IDLE: begin
               if (setup) begin
                  hold_wr    <= bus.pwrite;
                  hold_addr  <= bus.paddr;
                  hold_wdata <= bus.pwdata;
                  hold_strb  <= bus.pstrb;
                  rsp_err    <= 1'b0;
                  rsp_data   <= '0;
                  if (unaligned) begin
                     rsp_err <= 1'b1;
                     state   <= RESP;
                  end else if (bus.pwrite && (bus.pstrb == '0)) begin
                     // nothing to write: complete locally without touching the map
                     state <= RESP;
                  end else begin
                     state <= REQ;
                  end
               end
            end
            REQ: begin
               // a stalled cycle neither samples bus_ready nor starts the timeout
               if (!stall) begin
                  if (bus.bus_ready) begin
                     rsp_err  <= bus.bus_err;
                     rsp_data <= hold_wr ? '0 : bus.bus_rd_data;
                     state    <= RESP;
                  end else begin
                     cnt   <= '0;
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               // an ack in the same cycle as the timeout takes priority
               if (bus.bus_ready) begin
                  rsp_err  <= bus.bus_err;
                  rsp_data <= hold_wr ? '0 : bus.bus_rd_data;
                  state    <= RESP;
               end else begin
                  cnt <= cnt_nxt;
                  if (timeout_hit) begin
                     rsp_err     <= 1'b1;
                     rsp_data    <= '0;
                     timeout_evt <= 1'b1;
                     state       <= RESP;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // register-map request outputs, driven only while a request is outstanding
   always_comb begin
      req_act           = (state == REQ) || (state == WAIT);
      bus.bus_req       = (state == REQ);
      bus.bus_req_is_wr = req_act && hold_wr;
      bus.bus_addr      = req_act ? hold_addr  : '0;
      bus.bus_wr_data   = req_act ? hold_wdata : '0;
      for (int i = 0; i < STRB_W; i++) begin
         bus.bus_wr_biten[8*i +: 8] = {8{req_act && hold_strb[i]}};
      end
   end

   // APB response outputs, non-zero only in the single RESP cycle
   always_comb begin
      bus.pready  = (state == RESP);
      bus.pslverr = (state == RESP) && rsp_err;
      bus.prdata  = (state == RESP) ? rsp_data : '0;
   end

endmodule

// File: tb/tb_apb4_reg_bridge.sv
// Directed bench for apb4_reg_bridge: reads, partial writes, stall, timeout, error paths, reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked at the same point.
// Backpressure: register-map stall and ack are driven directly from the stimulus sequence.
module tb_apb4_reg_bridge;

   logic clk;
   logic rst;
   logic timeout_evt;
   int   n_assert;
   int   n_fail;

   apb4_reg_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus_if ();

   apb4_reg_bridge #(
      .DATA_WIDTH      (32),
      .ADDR_WIDTH      (11),
      .TIMEOUT_CYCLES  (16),
      .ERR_ON_UNALIGNED(1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_if),
      .timeout_evt(timeout_evt)
   );

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apb_setup(input logic wr, input logic [10:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb);
      bus_if.psel    = 1'b1;
      bus_if.penable = 1'b0;
      bus_if.pwrite  = wr;
      bus_if.paddr   = addr;
      bus_if.pwdata  = wdata;
      bus_if.pstrb   = strb;
   endtask

   task automatic apb_idle();
      bus_if.psel    = 1'b0;
      bus_if.penable = 1'b0;
   endtask

   // directed stimulus sequence
   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst                     = 1'b0;
      bus_if.psel             = 1'b0;
      bus_if.penable          = 1'b0;
      bus_if.pwrite           = 1'b0;
      bus_if.paddr            = '0;
      bus_if.pwdata           = '0;
      bus_if.pstrb            = '0;
      bus_if.bus_req_stall_wr = 1'b0;
      bus_if.bus_req_stall_rd = 1'b0;
      bus_if.bus_ready        = 1'b0;
      bus_if.bus_err          = 1'b0;
      bus_if.bus_rd_data      = '0;

      // reset state
      #1;
      chk("rst_pready",  bus_if.pready,       0);
      chk("rst_prdata",  bus_if.prdata,       0);
      chk("rst_pslverr", bus_if.pslverr,      0);
      chk("rst_bus_req", bus_if.bus_req,      0);
      chk("rst_addr",    bus_if.bus_addr,     0);
      chk("rst_biten",   bus_if.bus_wr_biten, 0);
      chk("rst_tevt",    timeout_evt,         0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // read with immediate ack; ack already high in IDLE must be ignored
      apb_setup(1'b0, 11'h010, 32'h0, 4'hF);
      bus_if.bus_ready   = 1'b1;
      bus_if.bus_rd_data = 32'hCAFEF00D;
      tick();
      chk("rd_req",      bus_if.bus_req,       1);
      chk("rd_is_wr",    bus_if.bus_req_is_wr, 0);
      chk("rd_addr",     bus_if.bus_addr,      11'h010);
      chk("rd_pready_0", bus_if.pready,        0);
      bus_if.penable = 1'b1;
      tick();
      chk("rd_pready",   bus_if.pready,  1);
      chk("rd_prdata",   bus_if.prdata,  32'hCAFEF00D);
      chk("rd_pslverr",  bus_if.pslverr, 0);
      chk("rd_req_off",  bus_if.bus_req, 0);
      apb_idle();
      bus_if.bus_ready   = 1'b0;
      bus_if.bus_rd_data = 32'h0;
      tick();
      chk("rd_pready_end", bus_if.pready, 0);
      chk("rd_prdata_end", bus_if.prdata, 0);

      // partial write, acked with error from WAIT
      apb_setup(1'b1, 11'h020, 32'h11223344, 4'b0101);
      tick();
      chk("pw_req",    bus_if.bus_req,       1);
      chk("pw_is_wr",  bus_if.bus_req_is_wr, 1);
      chk("pw_biten",  bus_if.bus_wr_biten,  32'h00FF00FF);
      chk("pw_wdata",  bus_if.bus_wr_data,   32'h11223344);
      bus_if.penable = 1'b1;
      tick();
      chk("pw_req_1cyc", bus_if.bus_req,  1'b0);
      chk("pw_wait_rdy", bus_if.pready,   0);
      bus_if.bus_ready = 1'b1;
      bus_if.bus_err   = 1'b1;
      tick();
      chk("pw_pready",  bus_if.pready,  1);
      chk("pw_pslverr", bus_if.pslverr, 1);
      chk("pw_prdata",  bus_if.prdata,  0);
      apb_idle();
      bus_if.bus_ready = 1'b0;
      bus_if.bus_err   = 1'b0;
      tick();

      // write stall for 3 cycles, then 16 WAIT cycles with ack on the last one
      apb_setup(1'b1, 11'h030, 32'hA5A5A5A5, 4'hF);
      bus_if.bus_req_stall_wr = 1'b1;
      tick();
      chk("st_req_c1", bus_if.bus_req,  1);
      chk("st_addr_c1", bus_if.bus_addr, 11'h030);
      bus_if.penable = 1'b1;
      tick();
      chk("st_req_c2", bus_if.bus_req, 1);
      tick();
      chk("st_req_c3", bus_if.bus_req, 1);
      tick();
      chk("st_req_c4",   bus_if.bus_req,      1);
      chk("st_addr_c4",  bus_if.bus_addr,     11'h030);
      chk("st_wdata_c4", bus_if.bus_wr_data,  32'hA5A5A5A5);
      chk("st_biten_c4", bus_if.bus_wr_biten, 32'hFFFFFFFF);
      bus_if.bus_req_stall_wr = 1'b0;
      tick();
      chk("st_wait_req", bus_if.bus_req, 0);
      repeat (15) tick();
      chk("st_w16_pready", bus_if.pready, 0);
      chk("st_w16_tevt",   timeout_evt,   0);
      chk("st_w16_addr",   bus_if.bus_addr, 11'h030);
      bus_if.bus_ready = 1'b1;
      tick();
      chk("st_pready",  bus_if.pready,  1);
      chk("st_pslverr", bus_if.pslverr, 0);
      chk("st_tevt",    timeout_evt,    0);
      apb_idle();
      bus_if.bus_ready = 1'b0;
      tick();

      // read timeout after 16 WAIT cycles, late ack ignored
      apb_setup(1'b0, 11'h040, 32'h0, 4'hF);
      bus_if.bus_rd_data = 32'hDEADBEEF;
      tick();
      bus_if.penable = 1'b1;
      tick();
      repeat (15) tick();
      chk("to_w16_pready", bus_if.pready, 0);
      chk("to_w16_tevt",   timeout_evt,   0);
      tick();
      chk("to_pready",  bus_if.pready,  1);
      chk("to_pslverr", bus_if.pslverr, 1);
      chk("to_prdata",  bus_if.prdata,  0);
      chk("to_tevt",    timeout_evt,    1);
      apb_idle();
      tick();
      chk("to_tevt_1cyc", timeout_evt,   0);
      chk("to_idle_rdy",  bus_if.pready, 0);
      bus_if.bus_ready = 1'b1;
      bus_if.bus_err   = 1'b1;
      tick();
      chk("late_ack_pready", bus_if.pready,  0);
      chk("late_ack_req",    bus_if.bus_req, 0);
      bus_if.bus_ready   = 1'b0;
      bus_if.bus_err     = 1'b0;
      bus_if.bus_rd_data = 32'h0;
      tick();

      // unaligned read: straight to error response
      apb_setup(1'b0, 11'h013, 32'h0, 4'hF);
      tick();
      chk("ua_req",     bus_if.bus_req, 0);
      chk("ua_pready",  bus_if.pready,  1);
      chk("ua_pslverr", bus_if.pslverr, 1);
      apb_idle();
      tick();
      chk("ua_req_after", bus_if.bus_req, 0);

      // empty-strobe write: straight to clean response
      apb_setup(1'b1, 11'h050, 32'h55AA55AA, 4'h0);
      tick();
      chk("es_req",     bus_if.bus_req, 0);
      chk("es_pready",  bus_if.pready,  1);
      chk("es_pslverr", bus_if.pslverr, 0);
      apb_idle();
      tick();

      // reset asserted during WAIT
      apb_setup(1'b0, 11'h060, 32'h0, 4'hF);
      tick();
      chk("rw_req", bus_if.bus_req, 1);
      bus_if.penable = 1'b1;
      tick();
      tick();
      chk("rw_wait_addr", bus_if.bus_addr, 11'h060);
      rst = 1'b0;
      #1;
      chk("rw_rst_req",    bus_if.bus_req,  0);
      chk("rw_rst_addr",   bus_if.bus_addr, 0);
      chk("rw_rst_pready", bus_if.pready,   0);
      apb_idle();
      tick();
      tick();
      rst = 1'b1;
      tick();
      tick();
      chk("rw_no_pready", bus_if.pready, 0);

      // normal transfer after reset release
      apb_setup(1'b0, 11'h070, 32'h0, 4'hF);
      bus_if.bus_ready   = 1'b1;
      bus_if.bus_rd_data = 32'h12345678;
      tick();
      chk("pr_req", bus_if.bus_req, 1);
      bus_if.penable = 1'b1;
      tick();
      chk("pr_pready",  bus_if.pready,  1);
      chk("pr_prdata",  bus_if.prdata,  32'h12345678);
      chk("pr_pslverr", bus_if.pslverr, 0);
      apb_idle();
      bus_if.bus_ready = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/apb4_reg_bridge.md
APB4_REG_BRIDGE -- requirements
Module: apb4_reg_bridge

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, 32, APB/register data width; multiple of 8.
- ADDR_WIDTH, 11, byte address width.
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before forced error; 0 disables the timeout.
- ERR_ON_UNALIGNED, 1, 1 = reject addresses not aligned to DATA_WIDTH/8.

REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.

REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB direction, 1 = write.
- paddr  in  ADDR_WIDTH  APB byte address.
- pwdata  in  DATA_WIDTH  APB write data.
- pstrb  in  DATA_WIDTH/8  APB byte strobes.
- pready  out  1  APB ready.
- prdata  out  DATA_WIDTH  APB read data.
- pslverr  out  1  APB error.
- bus_req  out  1  register request.
- bus_req_is_wr  out  1  request is a write.
- bus_addr  out  ADDR_WIDTH  request address.
- bus_wr_data  out  DATA_WIDTH  write data.
- bus_wr_biten  out  DATA_WIDTH  write bit enables.
- bus_req_stall_wr  in  1  register map cannot accept a write.
- bus_req_stall_rd  in  1  register map cannot accept a read.
- bus_ready  in  1  register map acknowledge.
- bus_err  in  1  register map error, valid with bus_ready.
- bus_rd_data  in  DATA_WIDTH  read data, valid with bus_ready.
- timeout_evt  out  1  one-cycle pulse when a transfer times out.

Function
REQ-004 The FSM SHALL have the states IDLE, REQ, WAIT and RESP.

REQ-005 In IDLE, psel=1 && penable=0 SHALL capture paddr, pwdata, pstrb and pwrite into holding registers and move to REQ on the next edge; no other input combination leaves IDLE.

REQ-006 The alignment check SHALL apply when ERR_ON_UNALIGNED=1: if paddr[log2(DATA_WIDTH/8)-1:0]!=0 at capture, the FSM SHALL go directly to RESP with error set, and bus_req SHALL never assert for that transfer.

REQ-007 A write with pstrb==0 SHALL go directly to RESP with no error and no bus_req.

REQ-008 Bit enables SHALL be formed as bus_wr_biten[8i+7:8i] = {8{pstrb[i]}}.

REQ-009 The request outputs SHALL be driven from the holding registers in REQ and WAIT, with bus_addr equal to the full captured byte address; bus_req SHALL be 1 only in REQ.

REQ-010 Stall handling in REQ: if the relevant stall is high (bus_req_stall_wr for writes, bus_req_stall_rd for reads), the FSM SHALL stay in REQ with bus_req held high and all request outputs stable; otherwise it SHALL leave REQ after exactly one cycle.

REQ-011 bus_ready SHALL be sampled in the non-stalled REQ cycle and in every WAIT cycle; bus_ready=1 SHALL capture bus_rd_data (reads only) and bus_err, then move to RESP.

REQ-012 The timeout counter, of width $clog2(TIMEOUT_CYCLES+1), SHALL clear on entry to WAIT and increment each WAIT cycle without bus_ready; stall cycles SHALL NOT count.

REQ-013 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL enter RESP with error=1 and read data=0, and timeout_evt SHALL pulse for one cycle.

REQ-014 If bus_ready and timeout coincide in the same cycle, bus_ready SHALL win and no timeout_evt is generated.

REQ-015 In RESP, pready SHALL be 1 for exactly one cycle, with pslverr equal to the captured error and prdata equal to the captured read data (0 for writes); the FSM SHALL then return to IDLE.

REQ-016 Outside RESP, pready, pslverr and prdata SHALL be 0.

REQ-017 Minimum latency SHALL be setup edge to pready = 2 cycles (IDLE -> REQ -> RESP), i.e. one wait state.

REQ-018 bus_ready or bus_err arriving in IDLE or RESP, including late acknowledges after a timeout, SHALL be ignored.

REQ-019 Once captured, a transfer SHALL run to completion even if psel deasserts; a new setup phase SHALL only be recognised in IDLE.

Reset
REQ-020 While rst=0, all outputs SHALL be 0 asynchronously, the state SHALL be IDLE, and the counter and holding registers SHALL be 0.

REQ-021 Reset asserted mid-transfer SHALL drop bus_req immediately and abandon the transfer; no pready is issued for it after release.

Verification
REQ-022 Read with immediate ack: paddr=0x010, bus_ready=1 and bus_rd_data=0xCAFEF00D in the REQ cycle -> pready=1 two cycles after setup, prdata=0xCAFEF00D, pslverr=0.

REQ-023 Partial write: pstrb=4'b0101, pwdata=0x11223344 -> bus_wr_biten=0x00FF00FF, bus_req_is_wr=1, one-cycle bus_req; bus_ready=1 with bus_err=1 -> pslverr=1.

REQ-024 Stall: bus_req_stall_wr=1 for 3 cycles -> bus_req high and stable for 4 cycles; the counter does not advance during the stall.

REQ-025 Timeout: TIMEOUT_CYCLES=16, no bus_ready -> timeout_evt pulse, pready with pslverr=1 and prdata=0; a bus_ready two cycles later is ignored.

REQ-026 Unaligned and empty-strobe accesses: paddr=0x013 -> pslverr=1 with no bus_req; a write with pstrb=0 -> pslverr=0 with no bus_req.

REQ-027 Reset mid-transfer: rst=0 during WAIT -> bus_req=0 and pready=0 immediately; after release the next transfer completes normally.
